// File: rtl/irq_defs.sv
// Shared definitions for the interrupt sequencer: register window offsets,
// FSM state encodings and the CAUSE word layout.
package irq_defs;

    localparam logic [1:0] IRQ_PEND  = 2'd0;
    localparam logic [1:0] IRQ_MASK  = 2'd1;
    localparam logic [1:0] IRQ_CAUSE = 2'd2;
    localparam logic [1:0] IRQ_CTRL  = 2'd3;

    localparam int CAUSE_VLD_BIT = 31;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

    function automatic logic [31:0] cause_word(input logic vld, input logic [2:0] id);
        logic [31:0] w;
        w                = '0;
        w[CAUSE_VLD_BIT] = vld;
        w[2:0]           = id;
        return w;
    endfunction

endpackage

// File: rtl/irq_sequencer_if.sv
// Peripheral-bus register window: CPU side is master, sequencer is slave.
// Single-cycle write strobe, read data combinational; no backpressure.
interface irq_sequencer_if;

    logic [1:0]  bus_addr;
    logic        bus_wr;
    logic        bus_rd;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;

    modport master (
        output bus_addr, bus_wr, bus_rd, bus_wdata,
        input  bus_rdata
    );

    modport slave (
        input  bus_addr, bus_wr, bus_rd, bus_wdata,
        output bus_rdata
    );

endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set index of the eligible vector wins.
// Purely combinational, zero latency; no backpressure.
module irq_prio_enc #(
    parameter int N = 4
) (
    input  logic [N-1:0] elig_i,
    output logic [2:0]   win_id_o,
    output logic         any_o
);

    always_comb begin
        win_id_o = '0;
        any_o    = |elig_i;
        // Scan downward so the lowest set index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (elig_i[i]) win_id_o = 3'(i);
        end
    end

endmodule

// File: rtl/irq_sequencer.sv
// Interrupt controller: edge-detects sources into PEND, masks and prioritises,
// raises IRQ 2 cycles after a source edge; one interrupt in service at a time.
module irq_sequencer
    import irq_defs::*;
#(
    parameter int NUM_SRC = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               Supervise,
    irq_sequencer_if.slave     bus,
    output logic               IRQ
);

    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic               ge_q, ge_d;
    logic               irq_q, irq_d;
    logic               cause_vld_q, cause_vld_d;
    logic [2:0]         cause_id_q, cause_id_d;
    irq_state_e         state_q, state_d;

    logic [NUM_SRC-1:0] elig;
    logic [2:0]         win_id;
    logic               any_elig;
    logic               wr_pend, wr_mask, wr_ctrl;
    logic               unused_bus;

    assign wr_pend = bus.bus_wr && (bus.bus_addr == IRQ_PEND);
    assign wr_mask = bus.bus_wr && (bus.bus_addr == IRQ_MASK);
    assign wr_ctrl = bus.bus_wr && (bus.bus_addr == IRQ_CTRL);

    assign unused_bus = ^{bus.bus_rd, bus.bus_wdata[31:NUM_SRC]};

    // New edges are OR-ed in after the W1C clear, so a same-cycle set wins.
    assign pend_d = (pend_q & ~(wr_pend ? bus.bus_wdata[NUM_SRC-1:0] : '0))
                  | (irq_src & ~src_q);
    assign mask_d = wr_mask ? bus.bus_wdata[NUM_SRC-1:0] : mask_q;
    assign ge_d   = wr_ctrl ? bus.bus_wdata[0] : ge_q;

    assign elig = ge_q ? (pend_q & mask_q) : '0;

    irq_prio_enc #(.N(NUM_SRC)) u_prio_enc (
        .elig_i   (elig),
        .win_id_o (win_id),
        .any_o    (any_elig)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (any_elig && !Supervise) state_d = ST_REQ;
            ST_REQ: begin
                if (Supervise)      state_d = ST_SERVICE;
                else if (!any_elig) state_d = ST_IDLE;
            end
            ST_SERVICE: if (!Supervise) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        irq_d       = (state_d == ST_REQ);
        cause_vld_d = cause_vld_q;
        cause_id_d  = cause_id_q;
        if (state_q == ST_REQ && state_d == ST_SERVICE) begin
            cause_vld_d = 1'b1;
            cause_id_d  = win_id;
        end else if (state_q == ST_SERVICE && state_d == ST_IDLE) begin
            cause_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_q       <= '0;
            pend_q      <= '0;
            mask_q      <= '0;
            ge_q        <= 1'b0;
            irq_q       <= 1'b0;
            cause_vld_q <= 1'b0;
            cause_id_q  <= '0;
        end else begin
            src_q       <= irq_src;
            pend_q      <= pend_d;
            mask_q      <= mask_d;
            ge_q        <= ge_d;
            irq_q       <= irq_d;
            cause_vld_q <= cause_vld_d;
            cause_id_q  <= cause_id_d;
        end
    end

    assign IRQ = irq_q;

    always_comb begin
        bus.bus_rdata = '0;
        case (bus.bus_addr)
            IRQ_PEND:  bus.bus_rdata[NUM_SRC-1:0] = pend_q;
            IRQ_MASK:  bus.bus_rdata[NUM_SRC-1:0] = mask_q;
            IRQ_CAUSE: bus.bus_rdata = cause_word(cause_vld_q, cause_id_q);
            IRQ_CTRL:  bus.bus_rdata[0] = ge_q;
            default:   bus.bus_rdata = '0;
        endcase
    end

endmodule

// File: doc/irq_sequencer.md
# irq_sequencer

Interrupt controller and sequencer between the peripheral interrupt sources and the single-cycle MIPS `Control` unit. It edge-detects and latches up to `NUM_SRC` source requests, applies mask and priority, and drives the `IRQ` input of `Control`. It tracks the CPU's kernel/user state through `Supervise` so that only one interrupt is in service at a time. Software reads and acknowledges interrupts through a small memory-mapped register window on the peripheral bus.

## Interface
- `NUM_SRC`, default 4: number of interrupt sources, 1..8.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `irq_src`  in  `NUM_SRC`  source request lines (timer, UART RX/TX, …), synchronous to `clk`; rising edge = event.
- `Supervise`  in  1  CPU in kernel mode (PC[31]); 1 while handler runs.
- `bus_addr`  in  2  word select within the window (byte addr[3:2]).
- `bus_wr`  in  1  write strobe, one cycle.
- `bus_rd`  in  1  read strobe (data is valid regardless of strobe).
- `bus_wdata`  in  32  write data.
- `bus_rdata`  out  32  read data, combinational from registers.
- `IRQ`  out  1  registered interrupt request to `Control`.

## Operation
- Registers: 0 PEND (R, W1C, `NUM_SRC` bits); 1 MASK (RW, 1 = enabled); 2 CAUSE (R: bit31 valid, bits[2:0] source id); 3 CTRL (bit0 global enable GE, RW). Unused bits read 0.
- Edge detect: a one-register delay of `irq_src`. `PEND[i]` is set when `irq_src[i]`=1 and delayed value=0. A W1C write clears bits. If set and clear hit the same bit in the same cycle, set wins.
- Eligible = `PEND & MASK`, gated by GE. Winner = lowest eligible index (fixed priority).
- FSM states:
  - IDLE: if eligible≠0 and `Supervise`=0, go to REQ.
  - REQ: `IRQ`=1. If `Supervise` rises, go to SERVICE and latch CAUSE={1, winner id}. If eligible becomes 0 (cleared, masked, GE=0) while `Supervise`=0, go to IDLE with `IRQ` dropped.
  - SERVICE: `IRQ`=0. New edges still latch into PEND. When `Supervise` falls (handler return), go to IDLE and clear CAUSE.valid.
- `Supervise`=1 in IDLE (syscall or exception handler running) blocks REQ entry. Nested interrupts are never issued.
- The CPU owns saving PC to $26. This block only sequences the request.

## Timing
- Reset values: `IRQ`=0, PEND=0, MASK=0, CAUSE=0, GE=0, edge-delay register=0, FSM=IDLE. `bus_rdata` reflects these immediately.
- Latency: source sampled high at edge k (low at k-1) → PEND set after edge k → FSM=REQ and `IRQ`=1 after edge k+1 (2 cycles).
- `IRQ` is a flop output, no combinational path from any input.
- `Supervise` rising sampled at edge j → `IRQ`=0 and CAUSE valid after edge j.
- Bus writes take effect after the strobe edge. A read in the same cycle returns the old value.
- Reset asserted mid-REQ or mid-SERVICE: all state returns to reset values asynchronously, with no spurious `IRQ` pulse on release.
- A source held high is a single event: it needs a low sample before it can set PEND again.

## Structure
- Shared package/header `irq_defs`: register offsets (`IRQ_PEND`=0, `IRQ_MASK`=1, `IRQ_CAUSE`=2, `IRQ_CTRL`=3), FSM state encodings (IDLE=0, REQ=1, SERVICE=2), CAUSE valid bit position.
- One natural sub-module, `irq_prio_enc`: combinational fixed-priority encoder that produces the winner id and an any-eligible flag from the eligible vector.
- Everything else (edge detect, registers, FSM, read mux) stays in `irq_sequencer`.

## Test plan
- Reset with GE=0 and MASK=0; pulse `irq_src[1]` → PEND reads 0x2 and `IRQ` stays 0. Then write MASK=0xF and CTRL=1 → `IRQ`=1 two edges later.
- GE=1, MASK=0xF; `irq_src[2]` and `irq_src[0]` rise in the same cycle; `IRQ` high for 3 cycles, then raise `Supervise` → CAUSE=0x80000000 (id 0), `IRQ`=0 after that edge.
- In SERVICE, pulse `irq_src[3]` → `IRQ` stays 0. Write PEND=0x1 (W1C), drop `Supervise` → IDLE, then `IRQ`=1 again within 2 cycles for remaining pending bit 2.
- In REQ, write PEND W1C clearing the only pending bit while `Supervise`=0 → `IRQ` returns to 0 after the edge following the write, and FSM=IDLE.
- W1C of bit 0 in the same cycle as a new `irq_src[0]` edge → PEND[0] remains 1.
- Assert `reset` low during SERVICE → `IRQ`, PEND, MASK, CAUSE and CTRL read 0 immediately. After release with `Supervise`=1 held, no `IRQ` is issued.
